mc_ctrl_unit_p: RTL and testbench

Parametrised next-generation multi-cycle controller for the ARM-subset datapath. It adds a 4-bit condition field with full NZCV evaluation and an internal flag register, a 4-bit opcode decode with the ALU-op mapping folded in, and illegal-opcode trapping. It also adds a memory ready handshake with an optional timeout. It sits between the instruction register / ALU flag outputs and the datapath mux/enable controls.

---
 rtl/mc_ctrl_unit_p.sv | 226 ++++++++++++++++++++++
 tb/tb_mc_ctrl_unit_p.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_unit_p.sv
// Multi-cycle controller for the ARM-subset datapath: condition evaluation over a
// registered NZCV, opcode decode with ALU-op mapping, illegal-op trap, memory handshake.
module mc_ctrl_unit_p #(
  parameter int MEM_WAIT  = 1,
  parameter int TIMEOUT   = 0,
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tbt,
  input  logic [3:0] opc,
  input  logic [3:0] cnd,
  input  logic       i,
  input  logic       ld,
  input  logic       lb,
  input  logic       s,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       mem_ready,
  output logic       pcsrc,
  output logic       pcwrite,
  output logic       mems,
  output logic       memwrite,
  output logic       memread,
  output logic       loadir,
  output logic       reg2,
  output logic       wreg,
  output logic       regwrite,
  output logic       srca,
  output logic [1:0] srcb,
  output logic [1:0] dreg,
  output logic [2:0] aluoperation,
  output logic [3:0] flags,
  output logic       undef,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    S_IF, S_ID, S_B0, S_B1, S_DT, S_LDM, S_LWB, S_STM,
    S_DPI, S_DPR, S_DPX, S_DWB, S_UND
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_MVN = 3'b101,
    OP_MOV = 3'b110
  } aluop_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    (TIMEOUT > 0) ? TIMEOUT_W'(TIMEOUT - 1) : '0;

  state_t               state, state_n;
  logic [3:0]           flg;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 rdy, tmo, cond_ok, is_cmp, arith, in_mem;
  aluop_t               dp_op;

  assign flags  = flg;
  assign rdy    = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign in_mem = (state == S_LDM) || (state == S_STM);
  assign is_cmp = (opc == 4'b0111);
  assign arith  = (opc == 4'b0000) || (opc == 4'b0001) || is_cmp;
  // A ready in the same cycle as the last allowed wait beats the timeout.
  assign tmo    = (MEM_WAIT != 0) && (TIMEOUT > 0) && in_mem && !rdy && (cnt == TMO_LAST);

  always_comb begin
    dp_op = OP_ADD;
    case (opc)
      4'b0000: dp_op = OP_ADD;
      4'b0001: dp_op = OP_SUB;
      4'b0010: dp_op = OP_AND;
      4'b0011: dp_op = OP_ORR;
      4'b0100: dp_op = OP_EOR;
      4'b0101: dp_op = OP_MVN;
      4'b0110: dp_op = OP_MOV;
      4'b0111: dp_op = OP_SUB;
      default: dp_op = OP_ADD;
    endcase
  end

  always_comb begin
    cond_ok = 1'b0;
    case (cnd)
      4'h0: cond_ok = flg[2];
      4'h1: cond_ok = !flg[2];
      4'h2: cond_ok = flg[1];
      4'h3: cond_ok = !flg[1];
      4'h4: cond_ok = flg[3];
      4'h5: cond_ok = !flg[3];
      4'h6: cond_ok = flg[0];
      4'h7: cond_ok = !flg[0];
      4'h8: cond_ok = flg[1] && !flg[2];
      4'h9: cond_ok = !flg[1] || flg[2];
      4'hA: cond_ok = (flg[3] == flg[0]);
      4'hB: cond_ok = (flg[3] != flg[0]);
      4'hC: cond_ok = !flg[2] && (flg[3] == flg[0]);
      4'hD: cond_ok = flg[2] || (flg[3] != flg[0]);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_n = S_IF;
    case (state)
      S_IF:  state_n = rdy ? S_ID : S_IF;
      S_ID: begin
        if (!cond_ok)                       state_n = S_IF;
        else if (tbt == 3'b101)             state_n = lb ? S_B1 : S_B0;
        else if (tbt == 3'b010)             state_n = S_DT;
        else if (tbt == 3'b000 && !opc[3])  state_n = i ? S_DPI : S_DPR;
        else                                state_n = S_UND;
      end
      S_B0:  state_n = S_IF;
      S_B1:  state_n = S_IF;
      S_DT:  state_n = ld ? S_STM : S_LDM;
      S_LDM: state_n = rdy ? S_LWB : (tmo ? S_IF : S_LDM);
      S_LWB: state_n = S_IF;
      S_STM: state_n = (rdy || tmo) ? S_IF : S_STM;
      S_DPI: state_n = S_DWB;
      S_DPR: state_n = S_DPX;
      S_DPX: state_n = S_DWB;
      S_DWB: state_n = S_IF;
      S_UND: state_n = S_IF;
      default: state_n = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IF;
      flg   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)
        cnt <= '0;
      else if (!rdy)
        cnt <= cnt + TIMEOUT_W'(1);
      // N/Z follow every flag-setting op; C/V only for the arithmetic ones.
      if ((state == S_DPI || state == S_DPX) && (s || is_cmp)) begin
        flg[3:2] <= {alu_n, alu_z};
        if (arith)
          flg[1:0] <= {alu_c, alu_v};
      end
    end
  end

  // Async reset forces S_IF at once, so outputs are also gated by rst to read all-zero.
  always_comb begin
    pcsrc        = 1'b0;
    pcwrite      = 1'b0;
    mems         = 1'b0;
    memwrite     = 1'b0;
    memread      = 1'b0;
    loadir       = 1'b0;
    reg2         = 1'b0;
    wreg         = 1'b0;
    regwrite     = 1'b0;
    srca         = 1'b0;
    srcb         = 2'd0;
    dreg         = 2'd0;
    aluoperation = OP_ADD;
    undef        = 1'b0;
    mem_err      = 1'b0;
    if (rst) begin
      mem_err = tmo;
      case (state)
        S_IF: begin
          memread = 1'b1;
          srcb    = 2'd1;
          loadir  = rdy;
          pcwrite = rdy;
        end
        S_ID:  srcb = 2'd2;
        S_B0: begin
          pcsrc   = 1'b1;
          pcwrite = 1'b1;
        end
        S_B1: begin
          pcsrc    = 1'b1;
          pcwrite  = 1'b1;
          regwrite = 1'b1;
          dreg     = 2'd1;
          wreg     = 1'b1;
        end
        S_DT: begin
          srca = 1'b1;
          srcb = 2'd3;
        end
        S_LDM: begin
          mems    = 1'b1;
          memread = 1'b1;
        end
        S_LWB: regwrite = 1'b1;
        S_STM: begin
          mems     = 1'b1;
          memwrite = 1'b1;
        end
        S_DPI: begin
          srca         = 1'b1;
          srcb         = 2'd3;
          aluoperation = dp_op;
        end
        S_DPR: reg2 = 1'b1;
        S_DPX: begin
          srca         = 1'b1;
          aluoperation = dp_op;
        end
        S_DWB: begin
          regwrite = !is_cmp;
          dreg     = 2'd2;
        end
        S_UND: undef = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit_p.sv
// Self-checking bench: per-instruction expected control traces are built from the
// instruction fields and a chosen mem_ready schedule, with a flag-register model.
module tb_mc_ctrl_unit_p;

  typedef struct packed {
    logic       pcsrc, pcwrite, mems, memwrite, memread, loadir, reg2, wreg, regwrite, srca;
    logic [1:0] srcb, dreg;
    logic [2:0] op;
    logic       undef, merr;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] tbt;
  logic [3:0] opc, cnd;
  logic       i, ld, lb, s;
  logic       alu_n, alu_z, alu_c, alu_v, mem_ready;
  logic       pcsrc, pcwrite, mems, memwrite, memread, loadir, reg2, wreg, regwrite, srca;
  logic [1:0] srcb, dreg;
  logic [2:0] aluoperation;
  logic [3:0] flags;
  logic       undef, mem_err;
  ctl_t       got;

  logic [3:0] mflags;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  mc_ctrl_unit_p #(.MEM_WAIT(1), .TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .tbt(tbt), .opc(opc), .cnd(cnd), .i(i), .ld(ld), .lb(lb), .s(s),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .mem_ready(mem_ready),
    .pcsrc(pcsrc), .pcwrite(pcwrite), .mems(mems), .memwrite(memwrite), .memread(memread),
    .loadir(loadir), .reg2(reg2), .wreg(wreg), .regwrite(regwrite), .srca(srca),
    .srcb(srcb), .dreg(dreg), .aluoperation(aluoperation), .flags(flags),
    .undef(undef), .mem_err(mem_err)
  );

  assign got = {pcsrc, pcwrite, mems, memwrite, memread, loadir, reg2, wreg, regwrite, srca,
                srcb, dreg, aluoperation, undef, mem_err};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // ARM conditions come in complementary pairs; bit 0 inverts the base predicate.
  function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  function automatic ctl_t if_ctl(input logic r);
    ctl_t e = '0;
    e.memread = 1'b1;
    e.srcb = 2'd1;
    e.loadir = r;
    e.pcwrite = r;
    return e;
  endfunction

  // Starts just after a rising edge; samples on the following falling edge.
  task automatic step(input string tag, input ctl_t e, input logic r);
    mem_ready = r;
    @(negedge clk);
    check(tag, 32'(got), 32'(e));
    check({tag, "_flags"}, 32'(flags), 32'(mflags));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [2:0] t, input logic [3:0] o, input logic [3:0] c,
                           input logic iv, input logic ldv, input logic lbv, input logic sv,
                           input logic [3:0] af, input int iw, input int mw);
    ctl_t e;
    tbt = t; opc = o; cnd = c; i = iv; ld = ldv; lb = lbv; s = sv;
    {alu_n, alu_z, alu_c, alu_v} = af;
    for (int k = 0; k < iw; k++) step("if_wait", if_ctl(1'b0), 1'b0);
    step("if", if_ctl(1'b1), 1'b1);
    e = '0; e.srcb = 2'd2;
    step("id", e, 1'($urandom));
    if (!cond_true(c, mflags)) return;
    if (t == 3'b101) begin
      e = '0; e.pcsrc = 1'b1; e.pcwrite = 1'b1;
      if (lbv) begin e.regwrite = 1'b1; e.dreg = 2'd1; e.wreg = 1'b1; end
      step(lbv ? "bl" : "b", e, 1'($urandom));
    end else if (t == 3'b010) begin
      e = '0; e.srca = 1'b1; e.srcb = 2'd3;
      step("dt", e, 1'($urandom));
      for (int k = 0; k < mw && k < 4; k++) begin
        e = '0; e.mems = 1'b1;
        if (ldv) e.memwrite = 1'b1; else e.memread = 1'b1;
        e.merr = (mw >= 4 && k == 3);
        step(ldv ? "stm_wait" : "ldm_wait", e, 1'b0);
      end
      if (mw < 4) begin
        e = '0; e.mems = 1'b1;
        if (ldv) e.memwrite = 1'b1; else e.memread = 1'b1;
        step(ldv ? "stm_done" : "ldm_done", e, 1'b1);
        if (!ldv) begin
          e = '0; e.regwrite = 1'b1;
          step("lwb", e, 1'($urandom));
        end
      end
    end else if (t == 3'b000 && !o[3]) begin
      logic [2:0] op = (o == 4'd7) ? 3'd1 : o[2:0];
      if (iv) begin
        e = '0; e.srca = 1'b1; e.srcb = 2'd3; e.op = op;
        step("dpi", e, 1'($urandom));
      end else begin
        e = '0; e.reg2 = 1'b1;
        step("dpr", e, 1'($urandom));
        e = '0; e.srca = 1'b1; e.op = op;
        step("dpx", e, 1'($urandom));
      end
      if (sv || o == 4'd7) begin
        mflags[3:2] = af[3:2];
        if (o == 4'd0 || o == 4'd1 || o == 4'd7) mflags[1:0] = af[1:0];
      end
      e = '0; e.regwrite = (o != 4'd7); e.dreg = 2'd2;
      step("dwb", e, 1'($urandom));
    end else begin
      e = '0; e.undef = 1'b1;
      step("und", e, 1'($urandom));
    end
  endtask

  initial begin
    ctl_t e;
    rst = 1'b0; mem_ready = 1'b1; mflags = '0;
    tbt = '0; opc = '0; cnd = 4'hE; i = 0; ld = 0; lb = 0; s = 0;
    {alu_n, alu_z, alu_c, alu_v} = '0;
    #1;
    check("rst_outputs", 32'(got), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("if_after_rst", 32'(got), 32'(if_ctl(1'b1)));
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // ADD reg, s=1, ALU N0 Z1 C1 V0 -> flags 0110
    run_instr(3'b000, 4'd0, 4'hE, 0, 0, 0, 1, 4'b0110, 0, 0);
    check("add_flags", 32'(flags), 32'b0110);
    // CMP Z=1 then BEQ taken
    run_instr(3'b000, 4'd7, 4'hE, 0, 0, 0, 0, 4'b0110, 0, 0);
    run_instr(3'b101, 4'd0, 4'h0, 0, 0, 0, 0, 4'b0000, 0, 0);
    // CMP Z=0 then BEQ not taken
    run_instr(3'b000, 4'd7, 4'hE, 1, 0, 0, 0, 4'b0000, 1, 0);
    run_instr(3'b101, 4'd0, 4'h0, 0, 0, 0, 0, 4'b0000, 0, 0);
    // Load with 3 wait cycles (ready wins at the last allowed wait)
    run_instr(3'b010, 4'd0, 4'hE, 0, 0, 0, 0, 4'b0000, 2, 3);
    // Store stuck: timeout on the 4th STM cycle
    run_instr(3'b010, 4'd0, 4'hE, 0, 1, 0, 0, 4'b0000, 0, 9);
    // Load stuck: timeout skips LWB
    run_instr(3'b010, 4'd0, 4'hE, 0, 0, 0, 0, 4'b0000, 0, 4);
    // Illegal opcode with s=1: trap, flags held
    run_instr(3'b000, 4'b1001, 4'hE, 0, 0, 0, 1, 4'b1111, 0, 0);
    // Branch with link
    run_instr(3'b101, 4'd0, 4'hE, 0, 0, 1, 0, 4'b0000, 0, 0);
    // Logical op with s=1: N/Z load, C/V hold
    run_instr(3'b000, 4'd2, 4'hE, 1, 0, 0, 1, 4'b1011, 0, 0);

    // Reset in the middle of LDM
    tbt = 3'b010; ld = 1'b0; cnd = 4'hE;
    step("pre_if", if_ctl(1'b1), 1'b1);
    e = '0; e.srcb = 2'd2; step("pre_id", e, 1'b0);
    e = '0; e.srca = 1'b1; e.srcb = 2'd3; step("pre_dt", e, 1'b0);
    e = '0; e.mems = 1'b1; e.memread = 1'b1; step("pre_ldm", e, 1'b0);
    rst = 1'b0;
    #1;
    check("midldm_rst_outputs", 32'(got), 32'h0);
    check("midldm_rst_flags", 32'(flags), 32'h0);
    mflags = '0;
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    check("if_after_rst2", 32'(got), 32'(if_ctl(1'b0)));
    @(posedge clk);
    #1;

    for (int n = 0; n < 300; n++) begin
      logic [2:0] t;
      logic [3:0] o, c;
      int unsigned r = $urandom_range(0, 9);
      if (r < 4) t = 3'b000;
      else if (r < 6) t = 3'b010;
      else if (r < 8) t = 3'b101;
      else t = 3'($urandom);
      o = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
      c = $urandom_range(0, 1) ? 4'hE : 4'($urandom);
      run_instr(t, o, c, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
